// File: rtl/gbp_pkg.sv
// Shared types and saturating-counter helpers for the gshare branch predictor.
// Counter helpers work on a zero-extended value plus a width, so any CTR_W can reuse them.
package gbp_pkg;

  localparam int GBP_CTR_W  = 2;
  localparam int GBP_HIST_W = 12;

  typedef logic [GBP_CTR_W-1:0] ctr_t;

  typedef struct packed {
    logic [GBP_HIST_W-1:0] idx;
    logic                  pred;
    logic [GBP_HIST_W-1:0] hist;
  } gbp_entry_t;

  // Weakly not-taken: one below the taken threshold.
  function automatic int unsigned ctr_init(input int w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

  function automatic int unsigned ctr_inc_sat(input int unsigned c, input int w);
    return (c == ((32'd1 << w) - 32'd1)) ? c : c + 32'd1;
  endfunction

  function automatic int unsigned ctr_dec_sat(input int unsigned c);
    return (c == 32'd0) ? c : c - 32'd1;
  endfunction

  function automatic logic ctr_is_taken(input int unsigned c, input int w);
    return ((c >> (w - 1)) & 32'd1) != 32'd0;
  endfunction

endpackage

// File: rtl/gbp_ctr_table.sv
// Counter table: one combinational read port, one read-modify-write update port.
// All counters reset in a single edge, so no reset sweep and no Stall during reset.
module gbp_ctr_table import gbp_pkg::*; #(
  parameter int HIST_W = GBP_HIST_W,
  parameter int CTR_W  = GBP_CTR_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [HIST_W-1:0] i_rd_idx,
  output logic              o_rd_taken,
  input  logic              i_wr_en,
  input  logic [HIST_W-1:0] i_wr_idx,
  input  logic              i_wr_taken
);

  localparam int DEPTH = 1 << HIST_W;

  logic [CTR_W-1:0] r_mem [DEPTH];
  logic [CTR_W-1:0] w_wr_old;
  logic [CTR_W-1:0] w_wr_new;

  assign w_wr_old   = r_mem[i_wr_idx];
  // Reads see the stored value, so a same-cycle update to the same index is not forwarded.
  assign o_rd_taken = ctr_is_taken(32'(r_mem[i_rd_idx]), CTR_W);

  always_comb begin
    w_wr_new = w_wr_old;
    if (i_wr_taken) w_wr_new = CTR_W'(ctr_inc_sat(32'(w_wr_old), CTR_W));
    else            w_wr_new = CTR_W'(ctr_dec_sat(32'(w_wr_old)));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= CTR_W'(ctr_init(CTR_W));
    end else if (i_wr_en) begin
      r_mem[i_wr_idx] <= w_wr_new;
    end
  end

endmodule

// File: rtl/gbp_spec_gshare.sv
// Speculative global-history predictor with in-order in-flight queue and mispredict repair.
// Define GBP_XOR_PC_EN for gshare indexing; otherwise the index is the history alone.
module gbp_spec_gshare import gbp_pkg::*; #(
  parameter int HIST_W   = GBP_HIST_W,
  parameter int CTR_W    = GBP_CTR_W,
  parameter int INFLIGHT = 8,
  parameter int PC_W     = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            Is_Branch,
  input  logic [PC_W-1:0] PC_In,
  output logic            Stall,
  output logic            pred,
  output logic            Pred_Valid,
  input  logic            Resolve_Valid,
  input  logic            Resolve_Taken,
  output logic            Mispredict
);

  localparam int              PTR_W = $clog2(INFLIGHT);
  localparam logic [PTR_W:0]  FULL  = (PTR_W + 1)'(INFLIGHT);

  logic [HIST_W-1:0] r_hist;
  gbp_entry_t        r_q [INFLIGHT];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W:0]    r_count;
  logic              r_pred;
  logic              r_pred_valid;
  logic              r_mispredict;

  logic [HIST_W-1:0] w_idx;
  logic              w_pred_dir;
  logic              w_stall;
  logic              w_resolve;
  logic              w_flush;
  logic              w_accept;
  gbp_entry_t        w_head;
  logic              w_unused;

`ifdef GBP_XOR_PC_EN
  assign w_idx = r_hist ^ PC_In[HIST_W+1:2];
`else
  assign w_idx = r_hist;
`endif

  assign w_unused  = ^{PC_In, w_head.hist[0]};
  assign w_head    = r_q[r_rd_ptr];
  assign w_stall   = (r_count == FULL);
  assign w_resolve = Resolve_Valid && (r_count != '0);
  assign w_flush   = w_resolve && (Resolve_Taken != w_head.pred);
  // A full queue drops the lookup even if a pop frees a slot this same edge.
  assign w_accept  = Is_Branch && !w_stall && !w_flush;

  gbp_ctr_table #(.HIST_W(HIST_W), .CTR_W(CTR_W)) u_table (
    .i_clk      (CLK),
    .i_reset    (RESET),
    .i_rd_idx   (w_idx),
    .o_rd_taken (w_pred_dir),
    .i_wr_en    (w_resolve),
    .i_wr_idx   (w_head.idx),
    .i_wr_taken (Resolve_Taken)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hist       <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_pred       <= 1'b0;
      r_pred_valid <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_pred_valid <= w_accept;
      r_mispredict <= w_flush;
      if (w_accept) r_pred <= w_pred_dir;
      if (w_flush) begin
        // Rebuild history as if the branch had been predicted correctly; younger entries are lost.
        r_hist   <= {Resolve_Taken, w_head.hist[HIST_W-1:1]};
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_accept) begin
          r_hist   <= {w_pred_dir, r_hist[HIST_W-1:1]};
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_resolve) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_accept, w_resolve})
          2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
          2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (w_accept) r_q[r_wr_ptr] <= '{idx: w_idx, pred: w_pred_dir, hist: r_hist};
  end

  assign Stall      = w_stall;
  assign pred       = r_pred;
  assign Pred_Valid = r_pred_valid;
  assign Mispredict = r_mispredict;

endmodule

// File: tb/tb_gbp_spec_gshare.sv
// Self-checking bench for gbp_spec_gshare: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_gbp_spec_gshare;

  localparam int HW  = 12;
  localparam int NQ  = 8;
  localparam int MSB = 1 << (HW - 1);

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Is_Branch = 1'b0;
  logic [31:0] PC_In = 32'd0;
  logic        Stall;
  logic        pred;
  logic        Pred_Valid;
  logic        Resolve_Valid = 1'b0;
  logic        Resolve_Taken = 1'b0;
  logic        Mispredict;

  int checks = 0;
  int failures = 0;

  gbp_spec_gshare dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .Is_Branch     (Is_Branch),
    .PC_In         (PC_In),
    .Stall         (Stall),
    .pred          (pred),
    .Pred_Valid    (Pred_Valid),
    .Resolve_Valid (Resolve_Valid),
    .Resolve_Taken (Resolve_Taken),
    .Mispredict    (Mispredict)
  );

  always #5 CLK = ~CLK;

  // Reference model: counters as plain integers, in-flight branches as a queue.
  typedef struct {
    int idx;
    bit pred;
    int hist;
  } ent_t;

  int   mCtr [1 << HW];
  ent_t mQ[$];
  int   mHist;
  bit   mPred;
  bit   mPv;
  bit   mMis;

  function automatic void modelReset();
    for (int i = 0; i < (1 << HW); i++) mCtr[i] = 1;
    mQ.delete();
    mHist = 0;
    mPred = 0;
    mPv   = 0;
    mMis  = 0;
  endfunction

  function automatic void modelStep(input bit isb, input logic [31:0] pc, input bit rv, input bit rt);
    bit   full;
    bit   res;
    bit   flush;
    bit   p;
    int   idx;
    ent_t e;
    full  = (mQ.size() == NQ);
    res   = rv && (mQ.size() > 0);
    flush = 0;
    idx   = mHist;
`ifdef GBP_XOR_PC_EN
    idx   = mHist ^ int'((pc >> 2) & 32'hFFF);
`endif
    p = (mCtr[idx] >= 2);
    if (res) begin
      e = mQ.pop_front();
      flush = (rt != e.pred);
      if (rt) mCtr[e.idx] = (mCtr[e.idx] == 3) ? 3 : mCtr[e.idx] + 1;
      else    mCtr[e.idx] = (mCtr[e.idx] == 0) ? 0 : mCtr[e.idx] - 1;
    end
    mPv  = isb && !full && !flush;
    mMis = flush;
    if (flush) begin
      mHist = (rt ? MSB : 0) | (e.hist >> 1);
      mQ.delete();
    end else if (mPv) begin
      mQ.push_back('{idx: idx, pred: p, hist: mHist});
      mHist = (p ? MSB : 0) | (mHist >> 1);
      mPred = p;
    end
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit isb, input logic [31:0] pc, input bit rv, input bit rt);
    Is_Branch     = isb;
    PC_In         = pc;
    Resolve_Valid = rv;
    Resolve_Taken = rt;
    @(posedge CLK);
    modelStep(isb, pc, rv, rt);
    #1;
    Is_Branch     = 1'b0;
    Resolve_Valid = 1'b0;
    Resolve_Taken = 1'b0;
  endtask

  task automatic doReset();
    RESET         = 1'b1;
    Is_Branch     = 1'b0;
    Resolve_Valid = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    modelReset();
    checkOutput("reset_pred",       pred,       0);
    checkOutput("reset_pred_valid", Pred_Valid, 0);
    checkOutput("reset_mispredict", Mispredict, 0);
    checkOutput("reset_stall",      Stall,      0);
  endtask

  task automatic macroRun(input logic [31:0] pc, output bit p);
    doReset();
    applyStimulus(1, 32'd0, 0, 0);
    applyStimulus(0, 32'd0, 1, 1);
    applyStimulus(1, pc, 0, 0);
    checkOutput("macro_pred_valid", Pred_Valid, 1);
    p = pred;
  endtask

  typedef struct {
    bit          isb;
    logic [31:0] pc;
    bit          rv;
    bit          rt;
    bit          ePv;
    bit          ePred;
    bit          eStall;
    bit          eMis;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit pa;
    bit pb;
    bit rtSel;

    // Warm-up: each fresh counter predicts not-taken, each taken resolve mispredicts and
    // shifts a 1 into the history until it reaches all ones. Then train counter 0xFFF.
    for (int k = 0; k <= 12; k++) begin
      vecs.push_back('{isb: 1, pc: (k == 0) ? 32'h100 : 32'h0, rv: 0, rt: 0,
                       ePv: 1, ePred: 0, eStall: 0, eMis: 0});
      vecs.push_back('{isb: 0, pc: 32'h0, rv: 1, rt: 1, ePv: 0, ePred: 0, eStall: 0, eMis: 1});
    end
    for (int k = 0; k < 3; k++) begin
      vecs.push_back('{isb: 1, pc: 32'h0, rv: 0, rt: 0, ePv: 1, ePred: 1, eStall: 0, eMis: 0});
      vecs.push_back('{isb: 0, pc: 32'h0, rv: 1, rt: 1, ePv: 0, ePred: 0, eStall: 0, eMis: 0});
    end

    doReset();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].isb, vecs[i].pc, vecs[i].rv, vecs[i].rt);
      checkOutput($sformatf("vec%0d_pred_valid", i), Pred_Valid, vecs[i].ePv);
      checkOutput($sformatf("vec%0d_mispredict", i), Mispredict, vecs[i].eMis);
      checkOutput($sformatf("vec%0d_stall", i),      Stall,      vecs[i].eStall);
      if (vecs[i].ePv) checkOutput($sformatf("vec%0d_pred", i), pred, vecs[i].ePred);
      if (i == 0) checkOutput("first_lookup_hist", dut.r_hist, 0);
    end
    checkOutput("trained_hist", dut.r_hist, 12'hFFF);
    checkOutput("saturated_ctr", dut.u_table.r_mem[12'hFFF], 3);

    // Fill to capacity, drop while full, then free a slot.
    doReset();
    for (int i = 0; i < NQ; i++) begin
      applyStimulus(1, 32'd0, 0, 0);
      checkOutput("fill_pred_valid", Pred_Valid, 1);
      checkOutput("fill_pred", pred, 0);
      checkOutput("fill_stall", Stall, (i == NQ - 1) ? 1 : 0);
    end
    applyStimulus(1, 32'd0, 0, 0);
    checkOutput("full_drop_pred_valid", Pred_Valid, 0);
    checkOutput("full_drop_stall", Stall, 1);
    applyStimulus(1, 32'd0, 1, 0);
    checkOutput("full_pop_drop_pred_valid", Pred_Valid, 0);
    checkOutput("full_pop_stall", Stall, 0);
    checkOutput("full_pop_mispredict", Mispredict, 0);
    applyStimulus(1, 32'd0, 1, 0);
    checkOutput("pushpop_pred_valid", Pred_Valid, 1);
    checkOutput("pushpop_count", dut.r_count, NQ - 1);
    applyStimulus(1, 32'd0, 0, 0);
    checkOutput("refill_stall", Stall, 1);
    applyStimulus(0, 32'd0, 1, 0);
    checkOutput("release_stall", Stall, 0);

    // Mispredict on the oldest of four: flush, repair, drop same-cycle lookup.
    doReset();
    for (int i = 0; i < 4; i++) applyStimulus(1, 32'd0, 0, 0);
    applyStimulus(1, 32'd0, 1, 1);
    checkOutput("mis_pulse", Mispredict, 1);
    checkOutput("mis_drop_pred_valid", Pred_Valid, 0);
    checkOutput("mis_repair_hist", dut.r_hist, 12'h800);
    checkOutput("mis_count", dut.r_count, 0);
    checkOutput("mis_stall", Stall, 0);
    applyStimulus(0, 32'd0, 0, 0);
    checkOutput("mis_single_cycle", Mispredict, 0);
    applyStimulus(0, 32'd0, 1, 1);
    checkOutput("empty_resolve_mis", Mispredict, 0);
    checkOutput("empty_resolve_hist", dut.r_hist, 12'h800);
    applyStimulus(1, 32'd0, 0, 0);
    checkOutput("post_repair_pred_valid", Pred_Valid, 1);
    checkOutput("post_repair_hist", dut.r_hist, 12'h400);

    // Lookup and update to the same counter in one cycle.
    doReset();
    applyStimulus(1, 32'd0, 0, 0);
    applyStimulus(1, 32'd0, 1, 0);
    checkOutput("collide_pred_valid", Pred_Valid, 1);
    checkOutput("collide_pred", pred, 0);
    checkOutput("collide_ctr", dut.u_table.r_mem[0], 0);
    checkOutput("collide_count", dut.r_count, 1);

    // PCs differing only in bit 2 under equal history.
    macroRun(32'h2000, pa);
    macroRun(32'h2004, pb);
`ifdef GBP_XOR_PC_EN
    checkOutput("macro_pc_a", pa, 1);
    checkOutput("macro_pc_b", pb, 0);
`else
    checkOutput("macro_pc_a", pa, 0);
    checkOutput("macro_pc_b", pb, 0);
`endif

    // Randomized traffic with occasional mid-flight resets.
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) doReset();
      rtSel = ($urandom_range(0, 3) != 0 && mQ.size() > 0) ? mQ[0].pred : 1'($urandom_range(0, 1));
      applyStimulus(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 99) < 35), rtSel);
      checkOutput("rand_pred_valid", Pred_Valid, mPv);
      checkOutput("rand_mispredict", Mispredict, mMis);
      checkOutput("rand_stall", Stall, (mQ.size() == NQ) ? 1 : 0);
      checkOutput("rand_hist", dut.r_hist, mHist);
      if (mPv) checkOutput("rand_pred", pred, mPred);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
